medium_array_reader: RTL

Read-side counterpart of the array accumulator: holds a DEPTH-entry byte array filled through a simple write port, then on a start command drains a programmable run of entries as a valid/ready stream. Keeps a running modulo-256 checksum of the bytes actually transferred, so the consumer can compare it against the writer-side sum. Sits between the array-fill logic and a downstream byte consumer.

---
 rtl/medium_array_reader_if.sv | 13 +
 rtl/medium_array_reader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/medium_array_reader_if.sv
// Byte stream from the array reader to its downstream consumer.
// The master drives valid/data/last and the slave drives ready.
interface medium_array_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/medium_array_reader.sv
// Byte array with a write port. On start it drains a programmable run of entries as a
// valid/ready stream and keeps a modulo-2^WIDTH checksum of the bytes actually accepted.
module medium_array_reader #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         start,
    input  logic [$clog2(DEPTH)-1:0]     rd_base,
    input  logic [$clog2(DEPTH):0]       rd_len,
    medium_array_reader_if.master        stream,
    output logic [WIDTH-1:0]             sum_out,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned Aw = $clog2(DEPTH);
    localparam int unsigned Lw = $clog2(DEPTH) + 1;
    localparam logic [Lw-1:0] DepthLen = Lw'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       state_q, state_d;
    logic [Aw-1:0]    idx_q, idx_d;
    logic [Lw-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [Lw-1:0]    run_len;
    logic [Aw-1:0]    next_idx;

    // cnt_q counts the entries still to transfer, including the one on out_data.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        sum_d    = sum_q;
        run_len  = (rd_len > DepthLen) ? DepthLen : rd_len;
        next_idx = idx_q + Aw'(1);

        case (state_q)
            StIdle: begin
                if (start) begin
                    sum_d = '0;
                    if (run_len != '0) begin
                        idx_d   = rd_base;
                        cnt_d   = run_len;
                        data_d  = mem_q[rd_base];
                        valid_d = 1'b1;
                        last_d  = (run_len == Lw'(1));
                        state_d = StRead;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                if (valid_q && stream.out_ready) begin
                    sum_d = sum_q + data_q;
                    if (cnt_q == Lw'(1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d  = next_idx;
                        cnt_d  = cnt_q - Lw'(1);
                        data_d = mem_q[next_idx];
                        last_d = (cnt_q == Lw'(2));
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The array is read combinationally above, so a same-edge write is not yet visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;
    assign stream.out_last  = last_q;
    assign sum_out          = sum_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
endmodule
